// File: rtl/rv32m_pkg.sv
// ---------------------------------------------------------------------------
// rv32m_pkg
// Shared types and constants for the iterative RV32M multiply/divide unit.
//   muldiv_op_t    : funct3 encodings of the M-extension operations
//   muldiv_state_t : sequencing FSM states
//   MULDIV_ITERS   : one iteration per operand bit
//   DIV0_QUOT      : quotient returned for a zero divisor
//   INT_MIN        : most negative 32-bit value (signed-overflow dividend)
// ---------------------------------------------------------------------------
package rv32m_pkg;

  localparam int          MULDIV_ITERS = 32;
  localparam logic [31:0] DIV0_QUOT    = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN      = 32'h8000_0000;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_ITER = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } muldiv_state_t;

  // Two's-complement negate when neg is set.
  function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
    return neg ? (~v + 32'd1) : v;
  endfunction

  // Operand A is treated as signed for MULH, MULHSU, DIV and REM.
  function automatic logic op_a_signed(input muldiv_op_t op);
    logic s;
    case (op)
      OP_MULH, OP_MULHSU, OP_DIV, OP_REM: s = 1'b1;
      default:                            s = 1'b0;
    endcase
    return s;
  endfunction

  // Operand B is treated as signed for MULH, DIV and REM.
  function automatic logic op_b_signed(input muldiv_op_t op);
    logic s;
    case (op)
      OP_MULH, OP_DIV, OP_REM: s = 1'b1;
      default:                 s = 1'b0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// ---------------------------------------------------------------------------
// muldiv_datapath
// Shared 64-bit accumulator datapath for radix-2 multiply and restoring divide.
//   clk_i, reset_i : clock, asynchronous active-high reset
//   load_i         : prepare cycle - load operand magnitudes, clear accumulator
//   step_i         : one iteration (one operand bit, MSB first)
//   op_i           : operation being executed
//   opa_i, opb_i   : raw operands captured at acceptance
//   result_o       : sign-corrected result word selected for op_i
// Multiply: acc = 2*acc + (a_bit ? b : 0), walking a from its MSB.
// Divide  : acc = {remainder, quotient}; dividend bits enter from shreg MSB.
// ---------------------------------------------------------------------------
module muldiv_datapath
  import rv32m_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        load_i,
  input  logic        step_i,
  input  muldiv_op_t  op_i,
  input  logic [31:0] opa_i,
  input  logic [31:0] opb_i,
  output logic [31:0] result_o
);

  logic [63:0] acc_q, acc_d;
  logic [31:0] shreg_q, shreg_d;   // multiplier / dividend magnitude, shifted left
  logic [31:0] breg_q, breg_d;     // multiplicand / divisor magnitude
  logic        neg_q, neg_d;       // final result needs negation
  logic        sa_s, sb_s;
  logic [32:0] trial_s;
  logic [63:0] prod_s;

  // Operand signs for the current operation.
  always_comb begin
    sa_s = op_a_signed(op_i) & opa_i[31];
    sb_s = op_b_signed(op_i) & opb_i[31];
  end

  // Next-state logic for prepare and iteration steps.
  always_comb begin
    acc_d   = acc_q;
    shreg_d = shreg_q;
    breg_d  = breg_q;
    neg_d   = neg_q;
    // Partial remainder shifted left with the next dividend bit, minus divisor.
    trial_s = {acc_q[63:32], shreg_q[31]} - {1'b0, breg_q};
    if (load_i) begin
      acc_d   = 64'd0;
      shreg_d = neg_if(sa_s, opa_i);
      breg_d  = neg_if(sb_s, opb_i);
      case (op_i)
        OP_MUL:                   neg_d = 1'b0;
        OP_MULH, OP_MULHSU:       neg_d = sa_s ^ sb_s;
        OP_MULHU:                 neg_d = 1'b0;
        // A zero divisor yields all-ones regardless of the dividend sign.
        OP_DIV:                   neg_d = (sa_s ^ sb_s) & (opb_i != 32'd0);
        OP_DIVU:                  neg_d = 1'b0;
        OP_REM:                   neg_d = sa_s;
        OP_REMU:                  neg_d = 1'b0;
        default:                  neg_d = 1'b0;
      endcase
    end else if (step_i) begin
      shreg_d = {shreg_q[30:0], 1'b0};
      if (op_i[2]) begin
        // trial_s[32] set means the trial subtraction went negative: restore.
        if (!trial_s[32]) begin
          acc_d = {trial_s[31:0], acc_q[30:0], 1'b1};
        end else begin
          acc_d = {acc_q[62:32], shreg_q[31], acc_q[30:0], 1'b0};
        end
      end else begin
        if (shreg_q[31]) begin
          acc_d = {acc_q[62:0], 1'b0} + {32'd0, breg_q};
        end else begin
          acc_d = {acc_q[62:0], 1'b0};
        end
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      acc_q   <= 64'd0;
      shreg_q <= 32'd0;
      breg_q  <= 32'd0;
      neg_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      shreg_q <= shreg_d;
      breg_q  <= breg_d;
      neg_q   <= neg_d;
    end
  end

  // Sign fixup and result word selection.
  always_comb begin
    prod_s = neg_q ? (~acc_q + 64'd1) : acc_q;
    case (op_i)
      OP_MUL:                      result_o = acc_q[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result_o = prod_s[63:32];
      OP_DIV, OP_DIVU:             result_o = neg_if(neg_q, acc_q[31:0]);
      OP_REM, OP_REMU:             result_o = neg_if(neg_q, acc_q[63:32]);
      default:                     result_o = acc_q[31:0];
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
// Iterative RV32M multiply/divide execute unit with start/busy/done handshake.
//   clk, reset        : core clock, asynchronous active-high reset
//   start, kill       : request (accepted in IDLE/DONE), synchronous abort
//   funct3            : M-extension operation select
//   rs1_val, rs2_val  : operands from the register file
//   rd                : destination register carried with the op
//   busy              : high in PREP, ITER, FIX
//   done              : one-cycle pulse with result/result_rd valid
//   result, result_rd : held until the next completed operation
// EARLY_OUT=1 lets divide-by-zero and INT_MIN/-1 finish straight from PREP.
// ---------------------------------------------------------------------------
module muldiv_unit
  import rv32m_pkg::*;
#(
  parameter int          XLEN      = 32,
  parameter int unsigned EARLY_OUT = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      result_rd
);

  muldiv_state_t   state_q;
  muldiv_op_t      op_q;
  logic [XLEN-1:0] opa_q, opb_q;
  logic [4:0]      rd_q;
  logic [4:0]      count_q;
  logic            busy_q, done_q;
  logic [XLEN-1:0] result_q;
  logic [4:0]      result_rd_q;

  logic            div0_s, ovf_s;
  logic [XLEN-1:0] special_val_s;
  logic [XLEN-1:0] dp_result_s;
  logic            dp_load_s, dp_step_s;

  // Special-case detection and their architecturally defined results.
  always_comb begin
    div0_s = op_q[2] && (opb_q == 32'd0);
    ovf_s  = ((op_q == OP_DIV) || (op_q == OP_REM)) &&
             (opa_q == INT_MIN) && (opb_q == DIV0_QUOT);
    if (div0_s) begin
      special_val_s = op_q[1] ? opa_q : DIV0_QUOT;
    end else begin
      special_val_s = op_q[1] ? 32'd0 : INT_MIN;
    end
  end

  // Datapath control decoded from the current state.
  always_comb begin
    dp_load_s = (state_q == ST_PREP);
    dp_step_s = (state_q == ST_ITER);
  end

  muldiv_datapath u_datapath (
    .clk_i    (clk),
    .reset_i  (reset),
    .load_i   (dp_load_s),
    .step_i   (dp_step_s),
    .op_i     (op_q),
    .opa_i    (opa_q),
    .opb_i    (opb_q),
    .result_o (dp_result_s)
  );

  // Sequencing FSM with iteration counter and registered handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_MUL;
      opa_q       <= 32'd0;
      opb_q       <= 32'd0;
      rd_q        <= 5'd0;
      count_q     <= 5'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= 32'd0;
      result_rd_q <= 5'd0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start && !kill) begin
            op_q    <= muldiv_op_t'(funct3);
            opa_q   <= rs1_val;
            opb_q   <= rs2_val;
            rd_q    <= rd;
            state_q <= ST_PREP;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
        ST_PREP: begin
          if (kill) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end else if ((EARLY_OUT != 0) && (div0_s || ovf_s)) begin
            result_q    <= special_val_s;
            result_rd_q <= rd_q;
            state_q     <= ST_DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
          end else begin
            count_q <= 5'(MULDIV_ITERS - 1);
            state_q <= ST_ITER;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        ST_ITER: begin
          if (kill) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end else if (count_q == 5'd0) begin
            state_q <= ST_FIX;
          end else begin
            count_q <= count_q - 5'd1;
          end
        end
        ST_FIX: begin
          if (kill) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end else begin
            result_q    <= dp_result_s;
            result_rd_q <= rd_q;
            state_q     <= ST_DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign result_rd = result_rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit
// Directed, table-driven bench for muldiv_unit. Two instances share stimulus:
// u_dut1 with EARLY_OUT=1 and u_dut0 with EARLY_OUT=0.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, kill;
  logic [2:0]  funct3;
  logic [31:0] rs1_val, rs2_val;
  logic [4:0]  rd;

  logic        busy1, done1, busy0, done0;
  logic [31:0] result1, result0;
  logic [4:0]  result_rd1, result_rd0;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  r;
    logic [31:0] exp;
    int          lat;   // latency of the EARLY_OUT=1 instance
    string       name;
  } vec_t;

  vec_t vecs[16];

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32), .EARLY_OUT(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .kill(kill), .funct3(funct3),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .rd(rd),
    .busy(busy1), .done(done1), .result(result1), .result_rd(result_rd1)
  );

  muldiv_unit #(.XLEN(32), .EARLY_OUT(0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .kill(kill), .funct3(funct3),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .rd(rd),
    .busy(busy0), .done(done0), .result(result0), .result_rd(result_rd0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one op at the current negedge and follow both instances to done.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] r, input logic [31:0] exp, input int lat,
                        input string name);
    int  d1;
    int  d0;
    logic busy_bad;
    d1 = 0;
    d0 = 0;
    busy_bad = 1'b0;
    start = 1'b1; funct3 = f; rs1_val = a; rs2_val = b; rd = r;
    for (int n = 1; n <= 40; n++) begin
      if (d1 != 0 && d0 != 0) break;
      @(negedge clk);
      // Scramble inputs: operands must have been captured at acceptance.
      start = 1'b0;
      rs1_val = $urandom; rs2_val = $urandom;
      rd = 5'($urandom); funct3 = 3'($urandom);
      if (d1 == 0) begin
        if (busy1 !== (n < lat)) busy_bad = 1'b1;
        if (done1 === 1'b1) begin
          d1 = n;
          chk({name, " result"}, result1, exp);
          chk({name, " rd"}, {27'd0, result_rd1}, {27'd0, r});
        end
      end
      if (d0 == 0 && done0 === 1'b1) begin
        d0 = n;
        chk({name, " result(eo0)"}, result0, exp);
        chk({name, " rd(eo0)"}, {27'd0, result_rd0}, {27'd0, r});
      end
    end
    chk({name, " latency"}, 32'(d1), 32'(lat));
    chk({name, " latency(eo0)"}, 32'(d0), 32'd35);
    chk({name, " busy window"}, {31'd0, busy_bad}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{3'b000, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 35, "MUL 7*-3"};
    vecs[1]  = '{3'b001, 32'h8000_0000,  32'h8000_0000, 5'd6,  32'h4000_0000, 35, "MULH min*min"};
    vecs[2]  = '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, 35, "MULHU"};
    vecs[3]  = '{3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, 35, "MULHSU"};
    vecs[4]  = '{3'b000, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd9,  32'h0000_0001, 35, "MUL -1*-1"};
    vecs[5]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,         5'd10, 32'hFFFF_FFFD, 35, "DIV -7/2"};
    vecs[6]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,         5'd11, 32'hFFFF_FFFF, 35, "REM -7/2"};
    vecs[7]  = '{3'b101, 32'd100,        32'd7,         5'd12, 32'd14,        35, "DIVU 100/7"};
    vecs[8]  = '{3'b111, 32'd100,        32'd7,         5'd13, 32'd2,         35, "REMU 100/7"};
    vecs[9]  = '{3'b101, 32'h8000_0000,  32'hFFFF_FFFF, 5'd14, 32'd0,         35, "DIVU min/max"};
    vecs[10] = '{3'b100, 32'd5,          32'd0,         5'd15, 32'hFFFF_FFFF, 2,  "DIV 5/0"};
    vecs[11] = '{3'b111, 32'd5,          32'd0,         5'd16, 32'd5,         2,  "REMU 5/0"};
    vecs[12] = '{3'b100, 32'hFFFF_FFFB,  32'd0,         5'd17, 32'hFFFF_FFFF, 2,  "DIV -5/0"};
    vecs[13] = '{3'b110, 32'hFFFF_FFF9,  32'd0,         5'd18, 32'hFFFF_FFF9, 2,  "REM -7/0"};
    vecs[14] = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 5'd19, 32'h8000_0000, 2,  "DIV ovf"};
    vecs[15] = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 5'd20, 32'd0,         2,  "REM ovf"};

    reset = 1'b1; start = 1'b0; kill = 1'b0;
    funct3 = 3'd0; rs1_val = 32'd0; rs2_val = 32'd0; rd = 5'd0;
    @(negedge clk);
    @(negedge clk);
    chk("reset busy", {30'd0, busy1, busy0}, 32'd0);
    chk("reset done", {30'd0, done1, done0}, 32'd0);
    chk("reset result", result1 | result0, 32'd0);
    chk("reset rd", {27'd0, result_rd1 | result_rd0}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Consecutive vectors start in the previous DONE cycle (back-to-back).
    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].exp, vecs[i].lat, vecs[i].name);
    end

    // Let everything settle, then a known op; kill in its DONE cycle.
    @(negedge clk);
    @(negedge clk);
    run_op(3'b000, 32'd6, 32'd7, 5'd3, 32'd42, 35, "MUL 6*7");
    start = 1'b1; kill = 1'b1; funct3 = 3'b000; rs1_val = 32'd1; rs2_val = 32'd1; rd = 5'd1;
    @(negedge clk);
    chk("kill in DONE busy", {31'd0, busy1}, 32'd0);
    chk("kill in DONE done", {31'd0, done1}, 32'd0);
    start = 1'b0; kill = 1'b0;

    // Start held high through busy, kill at c+10.
    begin
      logic saw_done;
      saw_done = 1'b0;
      start = 1'b1; funct3 = 3'b000; rs1_val = 32'd3; rs2_val = 32'd5; rd = 5'd9;
      for (int n = 1; n <= 10; n++) begin
        @(negedge clk);
        if (n == 10) kill = 1'b1;
      end
      @(negedge clk);
      chk("kill busy c+11", {30'd0, busy1, busy0}, 32'd0);
      start = 1'b0; kill = 1'b0;
      for (int n = 0; n < 30; n++) begin
        @(negedge clk);
        if (done1 === 1'b1 || done0 === 1'b1) saw_done = 1'b1;
      end
      chk("kill no done", {31'd0, saw_done}, 32'd0);
      chk("kill result held", result1, 32'd42);
      chk("kill result held(eo0)", result0, 32'd42);
      chk("kill rd held", {27'd0, result_rd1}, 32'd3);
    end
    run_op(3'b101, 32'd100, 32'd7, 5'd21, 32'd14, 35, "after kill DIVU");

    // Asynchronous reset in the middle of ITER, between clock edges.
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; rs1_val = 32'd9; rs2_val = 32'd9; rd = 5'd4;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 9; n++) @(negedge clk);
    chk("pre-reset busy", {31'd0, busy1}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async reset busy", {30'd0, busy1, busy0}, 32'd0);
    chk("async reset done", {30'd0, done1, done0}, 32'd0);
    chk("async reset result", result1 | result0, 32'd0);
    chk("async reset rd", {27'd0, result_rd1 | result_rd0}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_op(3'b111, 32'd100, 32'd7, 5'd0, 32'd2, 35, "post-reset REMU rd0");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
